// File: rtl/vfu_request_pipe.sv
// Request queue, in-order metadata tracker and registered writeback stage between
// the lane's slot-request arbiter and a single vector functional unit.
module vfu_request_pipe #(
    parameter int unsigned QUEUE_DEPTH  = 2,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CTRL_W       = 40
) (
    input  logic                                clock,
    input  logic                                reset,
    output logic                                io_in_ready,
    input  logic                                io_in_valid,
    input  logic [32:0]                         io_in_bits_src_0,
    input  logic [32:0]                         io_in_bits_src_1,
    input  logic [32:0]                         io_in_bits_src_2,
    input  logic [32:0]                         io_in_bits_src_3,
    input  logic [3:0]                          io_in_bits_opcode,
    input  logic [3:0]                          io_in_bits_executeMask,
    input  logic [1:0]                          io_in_bits_executeIndex,
    input  logic [5:0]                          io_in_bits_groupIndex,
    input  logic [4:0]                          io_in_bits_laneIndex,
    input  logic [1:0]                          io_in_bits_tag,
    input  logic [CTRL_W-1:0]                   io_in_bits_ctrl,
    output logic                                io_vfu_req_valid,
    input  logic                                io_vfu_req_ready,
    output logic [32:0]                         io_vfu_req_src_0,
    output logic [32:0]                         io_vfu_req_src_1,
    output logic [32:0]                         io_vfu_req_src_2,
    output logic [32:0]                         io_vfu_req_src_3,
    output logic [3:0]                          io_vfu_req_opcode,
    output logic [CTRL_W-1:0]                   io_vfu_req_ctrl,
    input  logic                                io_vfu_resp_valid,
    input  logic [32:0]                         io_vfu_resp_data,
    output logic                                io_out_valid,
    output logic [32:0]                         io_out_data,
    output logic [1:0]                          io_out_tag,
    output logic [5:0]                          io_out_groupIndex,
    output logic [4:0]                          io_out_laneIndex,
    output logic [1:0]                          io_out_executeIndex,
    output logic [3:0]                          io_out_executeMask,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   io_inflight,
    output logic                                io_errUnexpectedResp
);

    localparam int unsigned QPW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned QCW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned TPW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned TCW = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [32:0]       src_0;
        logic [32:0]       src_1;
        logic [32:0]       src_2;
        logic [32:0]       src_3;
        logic [3:0]        opcode;
        logic [3:0]        executeMask;
        logic [1:0]        executeIndex;
        logic [5:0]        groupIndex;
        logic [4:0]        laneIndex;
        logic [1:0]        tag;
        logic [CTRL_W-1:0] ctrl;
    } req_t;

    typedef struct packed {
        logic [1:0] tag;
        logic [5:0] groupIndex;
        logic [4:0] laneIndex;
        logic [1:0] executeIndex;
        logic [3:0] executeMask;
    } meta_t;

    req_t             q_mem [QUEUE_DEPTH];
    meta_t            t_mem [MAX_INFLIGHT];
    logic [QPW-1:0]   q_wr;
    logic [QPW-1:0]   q_rd;
    logic [QCW-1:0]   q_cnt;
    logic [TPW-1:0]   t_wr;
    logic [TPW-1:0]   t_rd;
    logic [TCW-1:0]   t_cnt;
    req_t             in_req;
    req_t             q_head;
    meta_t            t_head;
    meta_t            issue_meta;
    logic             in_fire;
    logic             issue_fire;
    logic             resp_fire;

    always_comb begin
        in_req.src_0        = io_in_bits_src_0;
        in_req.src_1        = io_in_bits_src_1;
        in_req.src_2        = io_in_bits_src_2;
        in_req.src_3        = io_in_bits_src_3;
        in_req.opcode       = io_in_bits_opcode;
        in_req.executeMask  = io_in_bits_executeMask;
        in_req.executeIndex = io_in_bits_executeIndex;
        in_req.groupIndex   = io_in_bits_groupIndex;
        in_req.laneIndex    = io_in_bits_laneIndex;
        in_req.tag          = io_in_bits_tag;
        in_req.ctrl         = io_in_bits_ctrl;
    end

    assign q_head = q_mem[q_rd];
    assign t_head = t_mem[t_rd];

    always_comb begin
        issue_meta.tag          = q_head.tag;
        issue_meta.groupIndex   = q_head.groupIndex;
        issue_meta.laneIndex    = q_head.laneIndex;
        issue_meta.executeIndex = q_head.executeIndex;
        issue_meta.executeMask  = q_head.executeMask;
    end

    // Handshakes look only at registered counts: a pop never frees a slot in the same cycle.
    assign io_in_ready      = (q_cnt != QCW'(QUEUE_DEPTH));
    assign io_vfu_req_valid = (q_cnt != '0) && (t_cnt < TCW'(MAX_INFLIGHT));
    assign in_fire          = io_in_valid && io_in_ready;
    assign issue_fire       = io_vfu_req_valid && io_vfu_req_ready;
    assign resp_fire        = io_vfu_resp_valid && (t_cnt != '0);

    assign io_vfu_req_src_0  = q_head.src_0;
    assign io_vfu_req_src_1  = q_head.src_1;
    assign io_vfu_req_src_2  = q_head.src_2;
    assign io_vfu_req_src_3  = q_head.src_3;
    assign io_vfu_req_opcode = q_head.opcode;
    assign io_vfu_req_ctrl   = q_head.ctrl;
    assign io_inflight       = t_cnt;

    always_ff @(posedge clock) begin
        if (in_fire)
            q_mem[q_wr] <= in_req;
        if (issue_fire)
            t_mem[t_wr] <= issue_meta;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_wr                 <= '0;
            q_rd                 <= '0;
            q_cnt                <= '0;
            t_wr                 <= '0;
            t_rd                 <= '0;
            t_cnt                <= '0;
            io_out_valid         <= 1'b0;
            io_out_data          <= '0;
            io_out_tag           <= '0;
            io_out_groupIndex    <= '0;
            io_out_laneIndex     <= '0;
            io_out_executeIndex  <= '0;
            io_out_executeMask   <= '0;
            io_errUnexpectedResp <= 1'b0;
        end else begin
            if (in_fire)
                q_wr <= (q_wr == QPW'(QUEUE_DEPTH - 1)) ? '0 : q_wr + 1'b1;
            if (issue_fire) begin
                q_rd <= (q_rd == QPW'(QUEUE_DEPTH - 1)) ? '0 : q_rd + 1'b1;
                t_wr <= (t_wr == TPW'(MAX_INFLIGHT - 1)) ? '0 : t_wr + 1'b1;
            end
            if (resp_fire)
                t_rd <= (t_rd == TPW'(MAX_INFLIGHT - 1)) ? '0 : t_rd + 1'b1;

            case ({in_fire, issue_fire})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: ;
            endcase

            case ({issue_fire, resp_fire})
                2'b10:   t_cnt <= t_cnt + 1'b1;
                2'b01:   t_cnt <= t_cnt - 1'b1;
                default: ;
            endcase

            io_out_valid <= resp_fire;
            if (resp_fire) begin
                io_out_data         <= io_vfu_resp_data;
                io_out_tag          <= t_head.tag;
                io_out_groupIndex   <= t_head.groupIndex;
                io_out_laneIndex    <= t_head.laneIndex;
                io_out_executeIndex <= t_head.executeIndex;
                io_out_executeMask  <= t_head.executeMask;
            end

            // An issue in this same cycle cannot be answered yet, so the registered count decides.
            if (io_vfu_resp_valid && (t_cnt == '0))
                io_errUnexpectedResp <= 1'b1;
        end
    end

endmodule

// File: doc/vfu_request_pipe.md
# vfu_request_pipe

Downstream consumer of the lane's single-input slot-request arbiter: accepts the arbitrated `SlotRequestToVFU` stream, buffers it in a small request queue, and issues it to one vector functional unit (VFU) with valid/ready. Request metadata is held in an in-order tracker so that each VFU result returns to the lane writeback path tagged with its slot tag, group, lane and execute index. The number of in-flight VFU operations is bounded, and any result arriving with no matching request is flagged.

## Interface
Parameters:
- `QUEUE_DEPTH`, 2: request queue entries; must be ≥1.
- `MAX_INFLIGHT`, 4: maximum issued-but-unanswered VFU operations; must be ≥1.
- `CTRL_W`, 40: width of the packed remaining request fields (mask, sign0, sign, reverse, average, saturate, vxrm, vSew, shifterSize, rem, popInit, maskType, narrow, unitSelet, floatMul, roundingMode). The block passes this field through opaquely.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: already decided as synchronous and active-high.
- `io_in_ready` out 1: request accept.
- `io_in_valid` in 1: request valid.
- `io_in_bits_src_0` .. `io_in_bits_src_3` in 33 each: operands.
- `io_in_bits_opcode` in 4: VFU opcode.
- `io_in_bits_executeMask` in 4: byte execute mask.
- `io_in_bits_executeIndex` in 2: execute index.
- `io_in_bits_groupIndex` in 6: group index.
- `io_in_bits_laneIndex` in 5: lane index.
- `io_in_bits_tag` in 2: slot tag.
- `io_in_bits_ctrl` in CTRL_W: packed remaining fields.
- `io_vfu_req_valid` out 1; `io_vfu_req_ready` in 1: VFU issue handshake.
- `io_vfu_req_src_0` .. `io_vfu_req_src_3` out 33 each.
- `io_vfu_req_opcode` out 4.
- `io_vfu_req_ctrl` out CTRL_W.
- `io_vfu_resp_valid` in 1: in-order VFU result strobe. There is no backpressure on this port.
- `io_vfu_resp_data` in 33: VFU result.
- `io_out_valid` out 1: one-cycle writeback pulse. There is no backpressure on this port.
- `io_out_data` out 33.
- `io_out_tag` out 2.
- `io_out_groupIndex` out 6.
- `io_out_laneIndex` out 5.
- `io_out_executeIndex` out 2.
- `io_out_executeMask` out 4.
- `io_inflight` out clog2(MAX_INFLIGHT+1): current tracker occupancy.
- `io_errUnexpectedResp` out 1: sticky error flag.

## Operation
**Request queue**
- FIFO of `QUEUE_DEPTH` full request entries.
- `io_in_ready = (qCount != QUEUE_DEPTH)`, using the registered count. A dequeue in the same cycle does not free a slot.
- Push on `io_in_valid && io_in_ready`.
- There is no bypass. An entry is visible at the queue head the cycle after its push.

**Issue**
- `io_vfu_req_valid = (qCount != 0) && (inflight < MAX_INFLIGHT)`, using registered values.
- `vfu_req_*` is driven from the queue head. It holds stable while valid and not ready.
- On issue fire: pop the queue and push {tag, groupIndex, laneIndex, executeIndex, executeMask} into the tracker FIFO (depth `MAX_INFLIGHT`).

**Response**
- When `io_vfu_resp_valid` is high and the tracker is non-empty, pop the tracker head.
- Next cycle: `io_out_valid=1` with `io_out_data` = registered resp_data and `io_out_*` = popped metadata.
- `io_vfu_resp_valid` with an empty tracker registered value: ignore the response, produce no `io_out_valid`, and set `io_errUnexpectedResp`. This holds even if an issue fires in the same cycle, because the VFU latency is ≥1.
- `io_errUnexpectedResp` clears only on reset.

**Counters and pointers**
- `inflight` = tracker count. Issue and response in the same cycle leave the count unchanged.
- When `inflight == MAX_INFLIGHT`, a response in cycle N permits issue at cycle N+1, not N.
- All FIFO pointers wrap modulo depth. Counts never exceed depth and never underflow.
- Ordering is strictly preserved: input order = issue order = output order.

**Reset**
- All counts and pointers = 0. `io_in_ready=1` from the first post-reset cycle.
- `io_vfu_req_valid=0`, `io_out_valid=0`, `io_out_*=0`, `io_inflight=0`, `io_errUnexpectedResp=0`.
- Reset mid-operation discards queued and in-flight requests. Later VFU responses for those requests set the error flag. Integration must quiesce the VFU alongside this block.

## Timing
- Input fire at cycle N → earliest `io_vfu_req_valid` at N+1.
- VFU response at cycle M → `io_out_valid` pulse at M+1, lasting exactly 1 cycle.
- Sustained throughput is 1 request/cycle when `QUEUE_DEPTH ≥ 2`, `io_vfu_req_ready=1`, and responses keep `inflight < MAX_INFLIGHT`.
- All outputs are registered or derived from registered state only. There is no combinational path from `io_in_valid` or `io_vfu_resp_valid` to any output.
- Exception: `io_in_ready` and `io_vfu_req_valid` depend only on registered counts.

## Test plan
- **Single request.** Push a request with tag=2, groupIndex=5, src_0=0x1_0000_0001 at cycle 0, with vfu ready. Expect issue at cycle 1. Drive resp_data=0x0_DEAD_BEEF at cycle 4. Expect `io_out_valid` at cycle 5 with tag=2, groupIndex=5 and data 0x0DEADBEEF. Expect `io_inflight` to go 1→0.
- **Backpressure.** Hold `io_vfu_req_ready=0` and offer 3 requests. Expect 2 accepted, `io_in_ready=0` afterwards, and `vfu_req_*` stable. Release ready. Expect issue in input order on consecutive cycles.
- **In-flight cap.** Keep `MAX_INFLIGHT=4` with no responses. Expect exactly 4 issues, then `io_vfu_req_valid=0` and `io_inflight=4`. Send one response at cycle N. Expect the next issue at N+1.
- **Simultaneous issue and response.** Fire issue and response in the same cycle. Expect `io_inflight` unchanged and the output metadata to match the oldest request.
- **Unexpected response.** Drive resp_valid with an empty tracker. Expect no `io_out_valid`, `io_errUnexpectedResp=1`, and the flag to stay set until reset.
- **Reset with traffic.** Assert reset with 2 queued and 3 in flight. The next cycle must show every output at its reset value and `io_in_ready=1`.
